// File: rtl/fewcore_pkg.sv
// Shared fewcore definitions: RV32I opcode/funct3 constants, LSU state encoding
// and small decode helpers used by the load/store unit.
package fewcore_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_FAULT,
    LSU_DONE
  } lsu_state_e;

  function automatic logic op_valid(input logic [6:0] opcode, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (opcode == OP_LOAD)
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
    else if (opcode == OP_STORE)
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return ok;
  endfunction

  // funct3[1:0] encodes access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = offset[0];
      2'b10:   mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store replication, byte-enable generation and load
// extract/extend. Purely combinational so a cache front end can reuse it.
module lsu_lane
  import fewcore_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    wdata = store_data;
    be    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << offset;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        be    = 4'b0011 << offset;
      end
      default: begin
        wdata = store_data;
        be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h000000, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0000, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// fewcore load/store unit: one data-memory access per accepted request over a
// req/ack handshake, with misalignment faulting and registered outputs.
module lsu
  import fewcore_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [11:0]     operation,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy,
  output logic            done,
  output logic            misaligned,
  output logic [XLEN-1:0] load_data
);

  lsu_state_e state, state_next;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] store_data_q;
  logic [2:0]      funct3_q;
  logic            we_q;

  logic [2:0]      funct3_in;
  logic [6:0]      opcode_in;
  logic            accept;
  logic            mis_in;

  logic [2:0]      lane_funct3;
  logic [1:0]      lane_offset;
  logic [XLEN-1:0] lane_store;
  logic [XLEN-1:0] lane_wdata;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_load;

  logic            unused_bits;

  assign funct3_in   = operation[9:7];
  assign opcode_in   = operation[6:0];
  assign accept      = (state == LSU_IDLE) && start && op_valid(opcode_in, funct3_in);
  assign mis_in      = is_misaligned(funct3_in, addr[1:0]);
  assign unused_bits = ^{operation[11:10], addr_q[XLEN-1:2]};

  // In IDLE the lane steers the incoming request so the memory outputs can be
  // registered on the accept edge; afterwards it works from the latched access.
  assign lane_funct3 = (state == LSU_IDLE) ? funct3_in  : funct3_q;
  assign lane_offset = (state == LSU_IDLE) ? addr[1:0]  : addr_q[1:0];
  assign lane_store  = (state == LSU_IDLE) ? store_data : store_data_q;

  lsu_lane u_lane (
    .funct3     (lane_funct3),
    .offset     (lane_offset),
    .store_data (lane_store),
    .rdata      (mem_rdata),
    .wdata      (lane_wdata),
    .be         (lane_be),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE:   if (accept) state_next = mis_in ? LSU_FAULT : LSU_ACCESS;
      LSU_ACCESS: if (mem_ack) state_next = LSU_DONE;
      LSU_FAULT:  state_next = LSU_IDLE;
      LSU_DONE:   state_next = LSU_IDLE;
      default:    state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      store_data_q <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      misaligned   <= 1'b0;
      load_data    <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            addr_q       <= addr;
            store_data_q <= store_data;
            funct3_q     <= funct3_in;
            we_q         <= (opcode_in == OP_STORE);
            busy         <= 1'b1;
            if (mis_in) begin
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= (opcode_in == OP_STORE);
              mem_addr  <= {addr[XLEN-1:2], 2'b00};
              mem_wdata <= lane_wdata;
              mem_be    <= lane_be;
            end
          end
        end
        LSU_ACCESS: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            done      <= 1'b1;
            load_data <= we_q ? '0 : lane_load;
          end
        end
        default: begin
          busy       <= 1'b0;
          done       <= 1'b0;
          misaligned <= 1'b0;
          load_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the fewcore datapath, directly downstream of the ALU. Takes the registered ALU result as effective address, together with the decoded operation and the rs2 store value, and performs one data-memory access over a req/ack handshake. Handles RV32I byte-lane steering, load sign/zero extension and misalignment detection. Returns load data to writeback with a one-cycle completion pulse.

## Interface
- XLEN, 32, datapath width; only 32 is supported, so there are 4 byte lanes
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request valid; sampled only in IDLE
- operation  in  12  funct/opcode concatenation as fed to the ALU; [9:7]=funct3, [6:0]=opcode
- addr  in  XLEN  effective address (ALU result)
- store_data  in  XLEN  rs2 value
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1=write
- mem_addr  out  XLEN  word address, {addr[31:2],2'b00}
- mem_wdata  out  XLEN  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle
- mem_rdata  in  XLEN  read word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- misaligned  out  1  one-cycle pulse with done on an alignment fault
- load_data  out  XLEN  extended load result, valid while done=1

## Operation
- Accepted ops:
  - Opcode 0000011: funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Opcode 0100011: funct3 000 sb, 001 sh, 010 sw.
- start with any other opcode or funct3 in IDLE is ignored: no access, no done.
- start while busy is ignored.
- Accept latches the access into internal registers: addr, store_data, funct3, we.
- FSM states: IDLE, ACCESS, FAULT, DONE.
  - IDLE -> ACCESS on a valid, aligned start.
  - IDLE -> FAULT on a valid, misaligned start.
  - ACCESS -> DONE on mem_ack.
  - FAULT -> IDLE.
  - DONE -> IDLE.
- Misaligned means:
  - halfword op with addr[0]=1;
  - word op with addr[1:0]!=0.
- FAULT produces done=1 and misaligned=1. It makes no memory request and leaves load_data at 0.
- Store steering (o = addr[1:0]):
  - sb: wdata={4{d[7:0]}}, be=4'b0001<<o.
  - sh: wdata={2{d[15:0]}}, be=4'b0011<<o.
  - sw: wdata=d, be=4'b1111.
- Loads drive mem_be with the same lane mask and mem_we=0.
- Load extraction:
  - Select byte/halfword from mem_rdata at bit offset 8*o.
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - mem_rdata is captured on the ack cycle.
- For stores, load_data=0 in DONE.

## Timing
- Reset values:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - busy=0, done=0, misaligned=0, load_data=0.
  - State IDLE.
- All outputs are registered.
- Start accepted at edge N:
  - mem_req=1 from N+1.
  - mem_we, mem_addr, mem_wdata and mem_be are stable from N+1 until the edge that samples mem_ack.
- mem_ack sampled high at edge M: mem_req=0 and done=1 after M, for one cycle.
- Minimum latency, with ack in the first request cycle: start edge N, done high in cycle N+2. Next start is accepted at edge N+3.
- Misaligned access: done=misaligned=1 in cycle N+1, back to IDLE after that.
- mem_ack in IDLE, FAULT or DONE is ignored.
- Reset asserted mid-access: all outputs clear immediately. A late mem_ack after reset release is ignored.

## Structure
- The shared package fewcore_pkg holds:
  - OP_LOAD=7'b0000011, OP_STORE=7'b0100011;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the lsu state enum.
- One sub-module, lsu_lane: combinational.
  - Store replication and byte-enable generation.
  - Load extract/extend from (funct3, offset, rdata).
  - Reused later by any cache front end.

## Test plan
- sw addr=0x100, data=0xDEADBEEF, ack in first cycle -> mem_addr=0x100, be=1111, we=1, wdata=0xDEADBEEF; done in cycle N+2; mem_req high exactly 1 cycle.
- sb addr=0x103, data=0x000000A5 -> be=1000, wdata=0xA5A5A5A5; sh addr=0x102, data=0x1234 -> be=1100, wdata=0x12341234.
- lb and lbu at addr=0x201, rdata=0x0000F000; memory stalls ack 3 cycles -> mem_req held 4 cycles. lb gives load_data=0xFFFFFFF0 and lbu gives 0x000000F0, each with a single-cycle done.
- lw addr=0x302 and lh addr=0x301 -> no mem_req; done=misaligned=1 in cycle N+1; load_data=0.
- start held high with a second op during ACCESS -> second op ignored. Opcode 0010011 in IDLE -> no activity.
- rst_n low during ACCESS -> mem_req and busy drop immediately. A mem_ack after reset release produces no done.
